ballot_tally: RTL and testbench



---
 rtl/ballot_tally.sv | 133 +++++++++++++
 tb/tb_ballot_tally.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ballot_tally.sv
// Clocked N-voter ballot: one session at a time, each voter counted once,
// closing on a full electorate or timeout, with registered outcome flags.
module ballot_tally #(
   parameter int  N_VOTERS = 3,
   parameter int  TIMEOUT  = 16,
   localparam int CNT_W    = $clog2(N_VOTERS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [N_VOTERS-1:0] vote_valid_i,
   input  logic [N_VOTERS-1:0] vote_val_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                pass_o,
   output logic                unanimous_o,
   output logic                tie_o,
   output logic                none_voted_o,
   output logic [CNT_W-1:0]    yes_cnt_o,
   output logic [CNT_W-1:0]    no_cnt_o,
   output logic [N_VOTERS-1:0] voted_o
);

   localparam int             TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W:0] N_EXT  = (CNT_W + 1)'(N_VOTERS);

   typedef enum logic [1:0] {IDLE, OPEN, DECIDE} state_t;

   state_t              state_q, state_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [CNT_W-1:0]    yes_q, yes_d, no_q, no_d;
   logic [N_VOTERS-1:0] voted_q, voted_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d, unan_q, unan_d;
   logic                tie_q, tie_d, none_q, none_d;

   logic [N_VOTERS-1:0] fresh;
   logic [CNT_W:0]      yes_x, no_x;

   function automatic logic [CNT_W-1:0] popcnt(input logic [N_VOTERS-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < N_VOTERS; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   // Only first-time voters are counted; later strobes from the same voter drop out here.
   assign fresh = vote_valid_i & ~voted_q;
   assign yes_x = {1'b0, yes_q};
   assign no_x  = {1'b0, no_q};

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      yes_d   = yes_q;
      no_d    = no_q;
      voted_d = voted_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      unan_d  = unan_q;
      tie_d   = tie_q;
      none_d  = none_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = OPEN;
               timer_d = '0;
               yes_d   = '0;
               no_d    = '0;
               voted_d = '0;
               pass_d  = 1'b0;
               unan_d  = 1'b0;
               tie_d   = 1'b0;
               none_d  = 1'b0;
            end
         end
         OPEN: begin
            voted_d = voted_q | fresh;
            yes_d   = yes_q + popcnt(fresh & vote_val_i);
            no_d    = no_q + popcnt(fresh & ~vote_val_i);
            timer_d = timer_q + TW'(1);
            if ((&voted_d) || (timer_q == T_LAST)) state_d = DECIDE;
         end
         DECIDE: begin
            state_d = IDLE;
            done_d  = 1'b1;
            pass_d  = {yes_q, 1'b0} > N_EXT;
            unan_d  = (yes_x == N_EXT) || (no_x == N_EXT);
            tie_d   = (yes_q == no_q) && (yes_q != '0);
            none_d  = (yes_x + no_x) == '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         yes_q   <= '0;
         no_q    <= '0;
         voted_q <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         unan_q  <= 1'b0;
         tie_q   <= 1'b0;
         none_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         yes_q   <= yes_d;
         no_q    <= no_d;
         voted_q <= voted_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         unan_q  <= unan_d;
         tie_q   <= tie_d;
         none_q  <= none_d;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = done_q;
   assign pass_o       = pass_q;
   assign unanimous_o  = unan_q;
   assign tie_o        = tie_q;
   assign none_voted_o = none_q;
   assign yes_cnt_o    = yes_q;
   assign no_cnt_o     = no_q;
   assign voted_o      = voted_q;

endmodule

// File: tb/tb_ballot_tally.sv
// Directed bench for ballot_tally: N=3/T=8, N=4/T=8 and N=2/T=1 instances
// driven by one linear sequence of steps with hand-computed expectations.
module tb_ballot_tally;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // N=3, TIMEOUT=8
   logic       start3 = 1'b0;
   logic [2:0] vv3 = '0, vval3 = '0;
   logic       busy3, done3, pass3, unan3, tie3, none3;
   logic [1:0] yes3, no3;
   logic [2:0] voted3;

   // N=4, TIMEOUT=8
   logic       start4 = 1'b0;
   logic [3:0] vv4 = '0, vval4 = '0;
   logic       busy4, done4, pass4, unan4, tie4, none4;
   logic [2:0] yes4, no4;
   logic [3:0] voted4;

   // N=2, TIMEOUT=1
   logic       start2 = 1'b0;
   logic [1:0] vv2 = '0, vval2 = '0;
   logic       busy2, done2, pass2, unan2, tie2, none2;
   logic [1:0] yes2, no2;
   logic [1:0] voted2;

   ballot_tally #(.N_VOTERS(3), .TIMEOUT(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .start_i(start3), .vote_valid_i(vv3), .vote_val_i(vval3),
      .busy_o(busy3), .done_o(done3), .pass_o(pass3), .unanimous_o(unan3), .tie_o(tie3),
      .none_voted_o(none3), .yes_cnt_o(yes3), .no_cnt_o(no3), .voted_o(voted3));

   ballot_tally #(.N_VOTERS(4), .TIMEOUT(8)) dut4 (
      .clk(clk), .rst_n(rst_n), .start_i(start4), .vote_valid_i(vv4), .vote_val_i(vval4),
      .busy_o(busy4), .done_o(done4), .pass_o(pass4), .unanimous_o(unan4), .tie_o(tie4),
      .none_voted_o(none4), .yes_cnt_o(yes4), .no_cnt_o(no4), .voted_o(voted4));

   ballot_tally #(.N_VOTERS(2), .TIMEOUT(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_i(start2), .vote_valid_i(vv2), .vote_val_i(vval2),
      .busy_o(busy2), .done_o(done2), .pass_o(pass2), .unanimous_o(unan2), .tie_o(tie2),
      .none_voted_o(none2), .yes_cnt_o(yes2), .no_cnt_o(no2), .voted_o(voted2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Packs the N=3 flags as {busy,done,pass,unan,tie,none}.
   function automatic logic [31:0] flags3();
      return 32'({busy3, done3, pass3, unan3, tie3, none3});
   endfunction

   initial begin
      logic saw_done;

      // Reset state
      #12;
      check("rst_flags3", flags3(), 32'b000000);
      check("rst_cnts3", 32'({yes3, no3, voted3}), 0);
      check("rst_all4", 32'({busy4, done4, pass4, unan4, tie4, none4, yes4, no4, voted4}), 0);
      rst_n = 1'b1;
      step();

      // Session 1: unanimous yes
      start3 = 1'b1;
      step();
      start3 = 1'b0; vv3 = 3'b111; vval3 = 3'b111;
      check("s1_open_busy", 32'(busy3), 1);
      check("s1_open_yes0", 32'(yes3), 0);
      step();
      vv3 = '0; vval3 = '0;
      check("s1_decide", flags3(), 32'b100000);
      check("s1_live_yes", 32'(yes3), 3);
      step();
      check("s1_done_flags", flags3(), 32'b011100);
      check("s1_counts", 32'({yes3, no3}), 32'b1100);
      $display("session unanimous: yes=%0d no=%0d pass=%0b unan=%0b", yes3, no3, pass3, unan3);
      step();
      check("s1_done_once", flags3(), 32'b001100);

      // Session 2: timeout tie
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      check("s2_flags_cleared", flags3(), 32'b100000);
      vv3 = 3'b001; vval3 = 3'b001;
      step();
      check("s2_live_yes", 32'(yes3), 1);
      vv3 = '0; vval3 = '0;
      step();
      vv3 = 3'b010; vval3 = 3'b000;
      step();
      vv3 = '0;
      for (int i = 0; i < 5; i++) step();
      check("s2_no_early_done", flags3(), 32'b100000);
      step();
      check("s2_done_flags", flags3(), 32'b010010);
      check("s2_counts", 32'({yes3, no3, voted3}), 32'b0101011);
      $display("session timeout tie: yes=%0d no=%0d tie=%0b voted=%b", yes3, no3, tie3, voted3);
      step();
      check("s2_done_once", 32'(done3), 0);

      // Session 3: duplicate vote from voter0 is ignored
      start3 = 1'b1;
      step();
      start3 = 1'b0; vv3 = 3'b001; vval3 = 3'b001;
      step();
      vv3 = '0; vval3 = '0;
      step();
      vv3 = 3'b001; vval3 = 3'b000;
      step();
      check("s3_dup_ignored", 32'({yes3, no3}), 32'b0100);
      vv3 = 3'b110; vval3 = 3'b010;
      step();
      vv3 = '0; vval3 = '0;
      step();
      check("s3_done_flags", flags3(), 32'b011000);
      check("s3_counts", 32'({yes3, no3}), 32'b1001);
      $display("session duplicate: yes=%0d no=%0d pass=%0b", yes3, no3, pass3);
      step();

      // Session 4: empty
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      check("s4_pass_cleared", 32'(pass3), 0);
      for (int i = 0; i < 8; i++) step();
      check("s4_decide_no_done", flags3(), 32'b100000);
      step();
      check("s4_done_flags", flags3(), 32'b010001);
      check("s4_counts", 32'({yes3, no3, voted3}), 0);
      $display("session empty: none_voted=%0b yes=%0d no=%0d", none3, yes3, no3);
      step();

      // Session 5: votes ignored in IDLE (also in the start cycle), start ignored in OPEN, abort
      vv3 = 3'b111; vval3 = 3'b111;
      step();
      check("s5_idle_ignore", 32'({busy3, yes3, voted3}), 0);
      start3 = 1'b1;
      step();
      check("s5_start_cycle_ignore", 32'({busy3, yes3, no3, voted3}), 32'b1_00_00_000);
      vv3 = 3'b001; vval3 = 3'b001;
      step();
      check("s5_no_restart", 32'({busy3, yes3, voted3}), 32'b1_01_001);
      vv3 = '0; vval3 = '0;
      rst_n = 1'b0;
      #1;
      check("s5_abort_flags", flags3(), 0);
      check("s5_abort_cnts", 32'({yes3, no3, voted3}), 0);
      start3 = 1'b0;
      #2;
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         saw_done = saw_done | done3;
      end
      check("s5_no_done_after_abort", 32'(saw_done), 0);
      $display("session aborted: busy=%0b done_seen=%0b", busy3, saw_done);

      // N=4: 2 yes + 2 no in one cycle
      start4 = 1'b1;
      step();
      start4 = 1'b0; vv4 = 4'b1111; vval4 = 4'b0011;
      step();
      vv4 = '0; vval4 = '0;
      check("n4_decide", 32'({busy4, done4}), 32'b10);
      step();
      check("n4_flags", 32'({busy4, done4, pass4, unan4, tie4, none4}), 32'b010010);
      check("n4_counts", 32'({yes4, no4, voted4}), 32'b010_010_1111);
      $display("session n4: yes=%0d no=%0d tie=%0b pass=%0b", yes4, no4, tie4, pass4);

      // N=2, TIMEOUT=1: single-cycle OPEN window, half the electorate is not a pass
      start2 = 1'b1;
      step();
      start2 = 1'b0; vv2 = 2'b01; vval2 = 2'b01;
      step();
      vv2 = '0; vval2 = '0;
      check("t1_decide", 32'({busy2, done2, yes2, voted2}), 32'b1_0_01_01);
      step();
      check("t1_flags", 32'({busy2, done2, pass2, unan2, tie2, none2}), 32'b010000);
      check("t1_counts", 32'({yes2, no2}), 32'b0100);
      $display("session t1: yes=%0d no=%0d pass=%0b", yes2, no2, pass2);
      step();
      check("t1_done_once", 32'(done2), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
